// File: rtl/mem_access_unit_if.sv
// Data-memory port of the RV32I memory access stage.
// The master drives address, read enable, byte strobes and write data; the slave returns read data.
interface mem_access_unit_if;
    logic        data_read;
    logic [31:0] data_addr;
    logic [3:0]  data_write;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output data_read,
        output data_addr,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  data_read,
        input  data_addr,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage between execute and write-back.
// It holds a word-aligned address for MEM_LATENCY cycles and returns extended load data.
module mem_access_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      memory_read_enable,
    input  logic                      memory_write_enable,
    input  logic [2:0]                funct3,
    input  logic [31:0]               alu_result,
    input  logic [31:0]               reg2_data,
    output logic                      stall,
    output logic                      done,
    output logic                      misaligned,
    output logic [31:0]               wb_memory_read_data,
    mem_access_unit_if.master         mem
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic [3:0]  strobe_q;
    logic [31:0] sdata_q;

    logic        is_load, is_store, is_mem, aligned, accept, last_cycle;
    logic [3:0]  strobe_d;
    logic [31:0] sdata_d, lane, load_ext;

    assign is_load    = memory_read_enable;
    assign is_store   = memory_write_enable & ~memory_read_enable;
    assign is_mem     = req_valid & (is_load | is_store);
    assign accept     = (state == IDLE) & is_mem & aligned;
    assign last_cycle = ((state == ACCESS) || (state == WAIT)) && (count == 4'd0);

    // funct3[1:0] picks the access width; every encoding beyond byte/halfword is a word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        aligned  = 1'b1;
        strobe_d = 4'b1111;
        sdata_d  = reg2_data;
        case (funct3[1:0])
            2'b00: begin
                strobe_d = 4'b0001 << alu_result[1:0];
                sdata_d  = {4{reg2_data[7:0]}};
            end
            2'b01: begin
                aligned  = ~alu_result[0];
                strobe_d = 4'b0011 << alu_result[1:0];
                sdata_d  = {2{reg2_data[15:0]}};
            end
            default: aligned = (alu_result[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        lane     = mem.data_out >> {off_q, 3'b000};
        load_ext = lane;
        case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_next     = state;
        stall          = 1'b0;
        done           = 1'b0;
        misaligned     = 1'b0;
        mem.data_read  = 1'b0;
        mem.data_addr  = 32'd0;
        mem.data_write = 4'd0;
        mem.data_in    = 32'd0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    if (aligned) begin
                        stall      = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall         = 1'b1;
                mem.data_addr = addr_q;
                if (load_q) begin
                    mem.data_read = 1'b1;
                end else begin
                    mem.data_write = strobe_q;
                    mem.data_in    = sdata_q;
                end
                state_next = (count == 4'd0) ? RESP : WAIT;
            end
            WAIT: begin
                stall         = 1'b1;
                mem.data_addr = addr_q;
                mem.data_read = load_q;
                if (count == 4'd0) state_next = RESP;
            end
            RESP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // IDLE outputs follow the request inputs, so reset must mask them directly.
        if (!rst) begin
            stall          = 1'b0;
            done           = 1'b0;
            misaligned     = 1'b0;
            mem.data_read  = 1'b0;
            mem.data_addr  = 32'd0;
            mem.data_write = 4'd0;
            mem.data_in    = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            count               <= 4'd0;
            addr_q              <= 32'd0;
            off_q               <= 2'd0;
            f3_q                <= 3'd0;
            load_q              <= 1'b0;
            strobe_q            <= 4'd0;
            sdata_q             <= 32'd0;
            wb_memory_read_data <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (accept) begin
                addr_q   <= {alu_result[31:2], 2'b00};
                off_q    <= alu_result[1:0];
                f3_q     <= funct3;
                load_q   <= is_load;
                strobe_q <= strobe_d;
                sdata_q  <= sdata_d;
                count    <= 4'(MEM_LATENCY - 1);
            end else if (((state == ACCESS) || (state == WAIT)) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
            if (last_cycle && load_q) wb_memory_read_data <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: latency-1 and latency-3 instances share one stimulus stream.
// A transaction-level model predicts every output each cycle; literal expectations pin the model.
module tb_mem_access_unit;

    typedef struct packed {
        logic        stall;
        logic        done;
        logic        mis;
        logic [31:0] wb;
        logic        read;
        logic [31:0] addr;
        logic [3:0]  wr;
        logic [31:0] din;
    } outs_t;

    typedef struct {
        bit          busy;
        int          k;
        bit          load;
        logic [31:0] addr;
        logic [1:0]  off;
        logic [2:0]  f3;
        logic [3:0]  strb;
        logic [31:0] sdata;
        logic [31:0] wb;
    } mstate_t;

    logic        clk, rst, req_valid, mre, mwe;
    logic [2:0]  funct3;
    logic [31:0] alu_result, reg2_data, mem_data;
    logic        stall1, done1, mis1, stall3, done3, mis3;
    logic [31:0] wb1, wb3;
    outs_t       out1, out3;
    outs_t       s1 [6];
    outs_t       s3 [6];
    mstate_t     m [2];
    int          checks = 0;
    int          failures = 0;
    bit          cmp_en = 0;

    mem_access_unit_if bus1 ();
    mem_access_unit_if bus3 ();
    assign bus1.data_out = mem_data;
    assign bus3.data_out = mem_data;

    mem_access_unit #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .memory_read_enable(mre),
        .memory_write_enable(mwe), .funct3(funct3), .alu_result(alu_result),
        .reg2_data(reg2_data), .stall(stall1), .done(done1), .misaligned(mis1),
        .wb_memory_read_data(wb1), .mem(bus1)
    );

    mem_access_unit #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .memory_read_enable(mre),
        .memory_write_enable(mwe), .funct3(funct3), .alu_result(alu_result),
        .reg2_data(reg2_data), .stall(stall3), .done(done3), .misaligned(mis3),
        .wb_memory_read_data(wb3), .mem(bus3)
    );

    assign out1 = {stall1, done1, mis1, wb1, bus1.data_read, bus1.data_addr, bus1.data_write, bus1.data_in};
    assign out3 = {stall3, done3, mis3, wb3, bus3.data_read, bus3.data_addr, bus3.data_write, bus3.data_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nbytes_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit addr_ok(input logic [2:0] f3, input logic [31:0] a);
        return (a % nbytes_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [2:0] f3);
        logic [31:0] val;
        val = rdata >> (8 * off);
        if (nbytes_of(f3) == 1) begin
            val = val & 32'hFF;
            if (!f3[2] && val[7]) val = val | 32'hFFFFFF00;
        end else if (nbytes_of(f3) == 2) begin
            val = val & 32'hFFFF;
            if (!f3[2] && val[15]) val = val | 32'hFFFF0000;
        end
        return val;
    endfunction

    // Model: k counts cycles since acceptance; cycles 1..L access memory, cycle L+1 reports done.
    always @(posedge clk or negedge rst) begin
        mstate_t nxt;
        for (int d = 0; d < 2; d++) begin
            nxt = m[d];
            if (!rst) begin
                nxt.busy = 0; nxt.k = 0; nxt.load = 0; nxt.wb = 32'd0;
            end else if (nxt.busy) begin
                if (nxt.load && nxt.k == lat_of(d)) nxt.wb = extend(mem_data, nxt.off, nxt.f3);
                if (nxt.k == lat_of(d) + 1) nxt.busy = 0;
                else nxt.k = nxt.k + 1;
            end else if (req_valid && (mre || mwe) && addr_ok(funct3, alu_result)) begin
                nxt.busy  = 1;
                nxt.k     = 1;
                nxt.load  = mre;
                nxt.addr  = alu_result & 32'hFFFFFFFC;
                nxt.off   = alu_result[1:0];
                nxt.f3    = funct3;
                nxt.strb  = 4'(((1 << nbytes_of(funct3)) - 1) << alu_result[1:0]);
                for (int i = 0; i < 4; i++)
                    nxt.sdata[8*i +: 8] = 8'(reg2_data >> (8 * (i % nbytes_of(funct3))));
            end
            m[d] <= nxt;
        end
    end

    function automatic outs_t expect_out(input int d);
        outs_t o;
        o    = '0;
        o.wb = m[d].wb;
        if (!rst) return '0;
        if (!m[d].busy) begin
            if (req_valid && (mre || mwe)) begin
                if (addr_ok(funct3, alu_result)) o.stall = 1'b1;
                else o.mis = 1'b1;
            end
        end else if (m[d].k <= lat_of(d)) begin
            o.stall = 1'b1;
            o.addr  = m[d].addr;
            if (m[d].load) begin
                o.read = 1'b1;
            end else if (m[d].k == 1) begin
                o.wr  = m[d].strb;
                o.din = m[d].sdata;
            end
        end else begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic cmp(input string tag, input outs_t a, input outs_t e);
        check({tag, "_stall"}, 32'(a.stall), 32'(e.stall));
        check({tag, "_done"}, 32'(a.done), 32'(e.done));
        check({tag, "_misaligned"}, 32'(a.mis), 32'(e.mis));
        check({tag, "_wb"}, a.wb, e.wb);
        check({tag, "_data_read"}, 32'(a.read), 32'(e.read));
        check({tag, "_data_addr"}, a.addr, e.addr);
        check({tag, "_data_write"}, 32'(a.wr), 32'(e.wr));
        check({tag, "_data_in"}, a.din, e.din);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("lat1", out1, expect_out(0));
            cmp("lat3", out3, expect_out(1));
        end
    end

    task automatic clear_inputs();
        req_valid = 0; mre = 0; mwe = 0; funct3 = 3'd0; alu_result = 32'd0; reg2_data = 32'd0;
    endtask

    // Issues one request in cycle 0 and records both instances for cycles 0..5.
    task automatic run_req(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int mid);
        mem_data = rdata;
        @(posedge clk); #1;
        req_valid = 1; mre = ld; mwe = st; funct3 = f3; alu_result = addr; reg2_data = wdata;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s1[c] = out1;
            s3[c] = out3;
            @(posedge clk); #1;
            clear_inputs();
            if (c + 1 == mid) begin
                req_valid = 1; mre = 1; funct3 = 3'b010; alu_result = 32'h300;
            end
        end
    endtask

    function automatic int count_reads(input int which);
        int n;
        n = 0;
        for (int c = 0; c < 6; c++) n += (which == 1) ? int'(s1[c].read) : int'(s3[c].read);
        return n;
    endfunction

    function automatic int count_writes(input int which);
        int n;
        n = 0;
        for (int c = 0; c < 6; c++) n += (which == 1) ? int'(s1[c].wr != 0) : int'(s3[c].wr != 0);
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        mem_data = 32'd0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1; mre = 1; funct3 = 3'b010; alu_result = 32'h100;
        @(negedge clk);
        check("reset_stall1", 32'(stall1), 32'd0);
        check("reset_stall3", 32'(stall3), 32'd0);
        check("reset_read1", 32'(bus1.data_read), 32'd0);
        check("reset_wb1", wb1, 32'd0);
        clear_inputs();
        #2 rst = 1'b1;
        cmp_en = 1;

        run_req(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, -1);
        check("lw_c0_stall", 32'(s1[0].stall), 32'd1);
        check("lw_c1_read", 32'(s1[1].read), 32'd1);
        check("lw_c1_addr", s1[1].addr, 32'h100);
        check("lw_c1_stall", 32'(s1[1].stall), 32'd1);
        check("lw_c2_read", 32'(s1[2].read), 32'd0);
        check("lw_c2_stall", 32'(s1[2].stall), 32'd0);
        check("lw_c2_done", 32'(s1[2].done), 32'd1);
        check("lw_c2_wb", s1[2].wb, 32'hDEADBEEF);

        run_req(1, 0, 3'b000, 32'h103, 32'd0, 32'h80112233, -1);
        check("lb_wb", s1[3].wb, 32'hFFFFFF80);
        run_req(1, 0, 3'b100, 32'h103, 32'd0, 32'h80112233, -1);
        check("lbu_wb", s1[3].wb, 32'h00000080);
        run_req(1, 0, 3'b001, 32'h102, 32'd0, 32'h80112233, -1);
        check("lh_wb", s1[3].wb, 32'hFFFF8011);

        run_req(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, -1);
        check("sb_strobe", 32'(s1[1].wr), 32'h2);
        check("sb_addr", s1[1].addr, 32'h200);
        check("sb_data", s1[1].din, 32'hA5A5A5A5);
        check("sb_write_cycles", count_writes(1), 1);
        check("sb_lat3_write_cycles", count_writes(3), 1);
        check("sb_lat3_done", 32'(s3[4].done), 32'd1);
        check("sb_wb_kept", s1[3].wb, 32'hFFFF8011);
        run_req(0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, -1);
        check("sh_strobe", 32'(s1[1].wr), 32'hC);
        check("sh_data", s1[1].din, 32'hBEEFBEEF);

        run_req(1, 0, 3'b010, 32'h102, 32'd0, 32'h55555555, -1);
        check("mis_lw_pulse", 32'(s1[0].mis), 32'd1);
        check("mis_lw_stall", 32'(s1[0].stall), 32'd0);
        check("mis_lw_reads", count_reads(1) + count_reads(3), 0);
        check("mis_lw_wb", s3[5].wb, 32'hFFFF8011);
        run_req(1, 0, 3'b001, 32'h101, 32'd0, 32'h55555555, -1);
        check("mis_lh_pulse", 32'(s3[0].mis), 32'd1);
        check("mis_lh_c1", 32'(s1[1].mis), 32'd0);
        check("mis_lh_reads", count_reads(1) + count_reads(3), 0);
        check("mis_lh_wb", s1[5].wb, 32'hFFFF8011);

        run_req(1, 0, 3'b010, 32'h10C, 32'd0, 32'h0BADCAFE, 2);
        check("lat3_read_cycles", count_reads(3), 3);
        check("lat3_c3_addr", s3[3].addr, 32'h10C);
        check("lat3_c3_done", 32'(s3[3].done), 32'd0);
        check("lat3_c4_done", 32'(s3[4].done), 32'd1);
        check("lat3_c4_wb", s3[4].wb, 32'h0BADCAFE);
        check("lat3_c5_stall", 32'(s3[5].stall), 32'd0);

        // Reset while the latency-3 load sits in WAIT.
        mem_data = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1; mre = 1; funct3 = 3'b010; alu_result = 32'h400;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        check("rst_ld_pre_read", 32'(bus3.data_read), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_ld_read", 32'(bus3.data_read), 32'd0);
        check("rst_ld_stall", 32'(stall3), 32'd0);
        check("rst_ld_addr", bus3.data_addr, 32'd0);
        check("rst_ld_wb", wb1, 32'd0);
        @(negedge clk); #2 rst = 1'b1;
        run_req(1, 0, 3'b010, 32'h104, 32'd0, 32'hCAFEF00D, -1);
        check("post_rst_wb1", s1[2].wb, 32'hCAFEF00D);
        check("post_rst_wb3", s3[4].wb, 32'hCAFEF00D);

        // Reset while the store strobes are driven.
        @(posedge clk); #1;
        req_valid = 1; mwe = 1; funct3 = 3'b010; alu_result = 32'h208; reg2_data = 32'h11223344;
        @(posedge clk); #1;
        clear_inputs();
        check("rst_st_pre_write", 32'(bus1.data_write), 32'hF);
        #1 rst = 1'b0;
        #1;
        check("rst_st_write1", 32'(bus1.data_write), 32'd0);
        check("rst_st_write3", 32'(bus3.data_write), 32'd0);
        check("rst_st_data_in", bus1.data_in, 32'd0);
        check("rst_st_stall", 32'(stall1), 32'd0);
        @(negedge clk); #2 rst = 1'b1;
        run_req(0, 1, 3'b000, 32'h203, 32'h0000003C, 32'h0, -1);
        check("post_rst_sb_strobe", 32'(s1[1].wr), 32'h8);
        check("post_rst_sb_data", s3[1].din, 32'h3C3C3C3C);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
